im_fetch_reader: RTL

- Read-side counterpart of the instruction-load counter. The load path writes instructions 0..N-1 into the instruction memory (IM); this block reads them back in order.
- On start, it latches the number of loaded instructions and issues sequential synchronous reads to the IM.
- It buffers returned words in a 2-entry skid FIFO and presents them downstream on a valid/ready handshake.
- It sits between the IM read port and the decode/execute stage; the control FSM triggers it after loading completes.

---
 rtl/im_fetch_reader.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/im_fetch_reader.sv
// -----------------------------------------------------------------------------
// im_fetch_reader
//
// Reads a freshly loaded program back out of the instruction memory (IM) in
// ascending address order and hands each word to the decode/execute stage
// over a valid/ready handshake.
//
// On an accepted start the number of loaded instructions is latched. Reads
// are then issued to the synchronous IM read port (one-cycle read latency).
// Returned words, each tagged with its address, land in a 2-entry skid FIFO
// whose head drives the downstream interface. A read is issued only if there
// is a FIFO slot for its data, counting words still in flight.
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous active-high reset; aborts any run in progress
//   start        one-cycle request to begin; honoured only when idle
//   load_count   number of valid instructions (addresses 0..load_count-1)
//   im_rd_en     IM read strobe
//   im_addr      IM read address (holds its last value between reads)
//   im_rdata     IM read data, valid the cycle after im_rd_en
//   instr_out    instruction at the FIFO head
//   instr_index  IM address of instr_out
//   instr_valid  FIFO non-empty
//   instr_ready  downstream accept; a word transfers when valid & ready
//   busy         high while reading or draining
//   done         one-cycle pulse after the last word has transferred
//
// All outputs are forced to zero while rst is high.
// -----------------------------------------------------------------------------
module im_fetch_reader #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] load_count,
    output logic              im_rd_en,
    output logic [ADDR_W-1:0] im_addr,
    input  logic [DATA_W-1:0] im_rdata,
    output logic [DATA_W-1:0] instr_out,
    output logic [ADDR_W-1:0] instr_index,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;

    logic [ADDR_W-1:0] next_addr_q, next_addr_d;
    logic [ADDR_W-1:0] count_q, count_d;
    // Address of the most recent read. It doubles as the tag of the word in
    // flight (only one read can be outstanding) and as the held im_addr.
    logic [ADDR_W-1:0] rd_addr_q;
    logic              inflight_q;

    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        occ_q, occ_d;

    logic [DATA_W-1:0] ent_data [2];
    logic [ADDR_W-1:0] ent_idx  [2];

    logic              fifo_valid;
    logic              pop;
    logic              push;
    logic              start_acc;
    logic              issue;
    logic              last_issue;
    logic              drained;
    logic [2:0]        level;

    // -------------------------------------------------------------------------
    // Handshake and issue qualification
    // -------------------------------------------------------------------------
    assign fifo_valid = (occ_q != 2'd0);
    assign pop        = fifo_valid & instr_ready;
    assign push       = inflight_q;
    assign start_acc  = (state_q == S_IDLE) && start;

    // Words that will still need a FIFO slot after this cycle's pop. A pop
    // always implies occ_q >= 1, so this never underflows.
    assign level = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};

    assign issue = (state_q == S_FETCH)
                && (next_addr_q < count_q)
                && (level < 3'd2);

    assign last_issue = issue
                     && (({1'b0, next_addr_q} + (ADDR_W+1)'(1)) == {1'b0, count_q});

    // Nothing left after this edge: no read outstanding, and the FIFO is
    // either already empty or its only word leaves this cycle. Finishing on
    // the transfer cycle itself puts done in the very next cycle.
    assign drained = !inflight_q
                  && ((occ_q == 2'd0) || ((occ_q == 2'd1) && pop));

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (load_count == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                if (last_issue) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drained) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs (all held at zero while in reset)
    // -------------------------------------------------------------------------
    always_comb begin
        im_rd_en    = 1'b0;
        im_addr     = '0;
        instr_valid = 1'b0;
        instr_out   = '0;
        instr_index = '0;
        busy        = 1'b0;
        done        = 1'b0;
        if (!rst) begin
            im_rd_en    = issue;
            im_addr     = issue ? next_addr_q : rd_addr_q;
            instr_valid = fifo_valid;
            if (fifo_valid) begin
                instr_out   = ent_data[rd_ptr_q];
                instr_index = ent_idx[rd_ptr_q];
            end
            busy = (state_q == S_FETCH) || (state_q == S_DRAIN);
            done = (state_q == S_DONE);
        end
    end

    // -------------------------------------------------------------------------
    // Read address generation
    // -------------------------------------------------------------------------
    always_comb begin
        next_addr_d = next_addr_q;
        count_d     = count_q;
        if (start_acc) begin
            count_d     = load_count;
            next_addr_d = '0;
        end else if (issue) begin
            next_addr_d = next_addr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            next_addr_q <= '0;
            count_q     <= '0;
            rd_addr_q   <= '0;
            inflight_q  <= 1'b0;
        end else begin
            next_addr_q <= next_addr_d;
            count_q     <= count_d;
            // Clearing this on reset is what discards a read that was in
            // flight when reset hit.
            inflight_q  <= issue;
            if (issue) begin
                rd_addr_q <= next_addr_q;
            end
        end
    end

    // -------------------------------------------------------------------------
    // 2-entry skid FIFO
    // -------------------------------------------------------------------------
    assign occ_d = occ_q + {1'b0, push} - {1'b0, pop};

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            occ_q <= occ_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            localparam logic SLOT = 1'(gi);
            logic [DATA_W-1:0] data_q;
            logic [ADDR_W-1:0] idx_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    data_q <= '0;
                    idx_q  <= '0;
                end else if (push && (wr_ptr_q == SLOT)) begin
                    data_q <= im_rdata;
                    idx_q  <= rd_addr_q;
                end
            end

            assign ent_data[gi] = data_q;
            assign ent_idx[gi]  = idx_q;
        end
    endgenerate

endmodule
